// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
//   Two-stage pipelined ALU with valid/ready handshakes on both sides.
//   S1 registers the computed result (y, flags, tag) at accept time.
//   S2 is the output register that drives the result ports.
//   A hidden carry register (cr) feeds ADC. It is updated at accept time, so
//   back-to-back ADC sequences chain correctly.
//
// Handshake: a transfer happens on a rising clk edge when valid & ready are both
//   high. A producer holds valid and its payload stable until the transfer.
//   Ready may depend on the consumer's ready but never on the offered payload.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_valid   operation offered
//   in_ready   block can accept (combinational from out_ready and stage valids)
//   op         000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 ADC
//   a, b       operands; shifts use b[$clog2(WIDTH)-1:0] as the shift amount
//   in_tag     opaque tag returned with the result
//   out_valid  result available
//   out_ready  consumer accepts
//   y          result
//   c,z,n,v    carry, zero, negative, signed overflow
//   out_tag    tag of the operation that produced y
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             c,
    output logic             z,
    output logic             n,
    output logic             v,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int M    = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_ADC = 3'b111;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             c;
        logic             z;
        logic             n;
        logic             v;
        logic [WIDTH-1:0] y;
    } res_t;

    logic       s1_valid, s2_valid;
    res_t       s1_q, s2_q;
    logic       cr;
    logic       s2_free;
    logic       accept;

    res_t             res;
    logic             upd_cr;
    logic [SH_W-1:0]  sh;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;

    // S2 can take a new value when it is empty or its result leaves this cycle.
    // S1 can take a new op when it is empty or it moves into a freeing S2.
    assign s2_free  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;

    assign sh = b[SH_W-1:0];

    always_comb begin
        res    = '0;
        upd_cr = 1'b0;
        // ADD and ADC share one adder; the carry-in is only live for ADC.
        sum_w  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) && cr};
        sub_w  = {1'b0, a} - {1'b0, b};
        // An extra bit on the shifted-out side catches the last bit lost.
        shl_w  = {1'b0, a} << sh;
        shr_w  = {a, 1'b0} >> sh;
        res.tag = in_tag;
        case (op)
            OP_ADD, OP_ADC: begin
                res.y  = sum_w[WIDTH-1:0];
                res.c  = sum_w[WIDTH];
                res.v  = (a[M] == b[M]) && (sum_w[M] != a[M]);
                upd_cr = 1'b1;
            end
            OP_SUB: begin
                res.y  = sub_w[WIDTH-1:0];
                res.c  = !sub_w[WIDTH];   // no borrow means a >= b
                res.v  = (a[M] != b[M]) && (sub_w[M] != a[M]);
                upd_cr = 1'b1;
            end
            OP_AND: res.y = a & b;
            OP_OR:  res.y = a | b;
            OP_XOR: res.y = a ^ b;
            OP_SHL: begin
                res.y  = shl_w[WIDTH-1:0];
                res.c  = shl_w[WIDTH];
                upd_cr = 1'b1;
            end
            OP_SHR: begin
                res.y  = shr_w[WIDTH:1];
                res.c  = shr_w[0];
                upd_cr = 1'b1;
            end
            default: res.y = '0;
        endcase
        res.z = (res.y == '0);
        res.n = res.y[M];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
            cr       <= 1'b0;
        end else begin
            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_q <= s1_q;
                end
            end
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_q <= res;
                end
            end
            if (accept && upd_cr) begin
                cr <= res.c;
            end
        end
    end

    assign out_valid = s2_valid;
    assign y         = s2_q.y;
    assign c         = s2_q.c;
    assign z         = s2_q.z;
    assign n         = s2_q.n;
    assign v         = s2_q.v;
    assign out_tag   = s2_q.tag;

endmodule
